// File: rtl/memory_bank_arbiter_pkg.sv
// Shared encodings for the two-port memory bank arbiter: FSM states, port ids
// and the width of the access-latency counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Wide enough for MEM_LATENCY-1 with MEM_LATENCY up to 15.
    localparam int COUNT_W = 4;

endpackage

// File: rtl/memory_bank_arbiter_rr_pick2.sv
// Combinational two-way request picker. With MEM_ARB_FIXED_PRIO_EN defined,
// port 0 wins every tie; otherwise ties go to the port named by prio.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic winner,
    output logic valid
);

    assign valid = req0 | req1;

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_prio;
    assign unused_prio = prio;
    assign winner      = req0 ? PORT0 : PORT1;
`else
    always_comb begin
        winner = PORT0;
        if (req0 && req1) begin
            winner = prio;
        end else if (req1) begin
            winner = PORT1;
        end
    end
`endif

endmodule

// File: rtl/memory_bank_arbiter.sv
// Two-port round-robin arbiter for one single-port memory bank; each grant holds
// the bank MEM_LATENCY cycles then acks. Define MEM_ARB_FIXED_PRIO_EN for fixed priority.
module memory_bank_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LINE_LENGTH  = 8,
    parameter int ADDRESS_SIZE = 2,
    parameter int MEM_LATENCY  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0,
    input  logic                    write0,
    input  logic [ADDRESS_SIZE-1:0] addr0,
    input  logic [LINE_LENGTH-1:0]  wdata0,
    output logic                    ack0,
    input  logic                    req1,
    input  logic                    write1,
    input  logic [ADDRESS_SIZE-1:0] addr1,
    input  logic [LINE_LENGTH-1:0]  wdata1,
    output logic                    ack1,
    output logic [LINE_LENGTH-1:0]  rdata,
    output logic                    busy,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [LINE_LENGTH-1:0]  mem_data_in,
    output logic                    mem_write,
    input  logic [LINE_LENGTH-1:0]  mem_data_out
);

    localparam logic [COUNT_W-1:0] COUNT_INIT = COUNT_W'(MEM_LATENCY - 1);

    state_t                  state;
    state_t                  next_state;
    logic                    prio;
    logic [COUNT_W-1:0]      count;
    logic                    win_id;
    logic                    lat_write;
    logic [ADDRESS_SIZE-1:0] lat_addr;
    logic [LINE_LENGTH-1:0]  lat_wdata;
    logic [LINE_LENGTH-1:0]  rdata_q;
    logic                    pick_winner;
    logic                    pick_valid;

    rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .prio   (prio),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_valid) next_state = ACCESS;
            ACCESS:  if (count == '0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request latches, latency counter, read capture and the round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio      <= PORT0;
            count     <= '0;
            win_id    <= PORT0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        win_id    <= pick_winner;
                        lat_write <= (pick_winner == PORT1) ? write1 : write0;
                        lat_addr  <= (pick_winner == PORT1) ? addr1  : addr0;
                        lat_wdata <= (pick_winner == PORT1) ? wdata1 : wdata0;
                        count     <= COUNT_INIT;
                    end
                end
                ACCESS: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end else begin
                        rdata_q <= mem_data_out;
                    end
                end
                RESP: begin
`ifndef MEM_ARB_FIXED_PRIO_EN
                    prio <= ~win_id;
`endif
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign ack0        = (state == RESP) && (win_id == PORT0);
    assign ack1        = (state == RESP) && (win_id == PORT1);
    assign mem_addr    = lat_addr;
    assign mem_data_in = lat_wdata;
    // Gating with reset keeps an aborted access from writing the bank.
    assign mem_write   = (state == ACCESS) && lat_write && (count == '0) && !reset;
    assign rdata       = rdata_q;

endmodule

// File: tb/tb_memory_bank_arbiter.sv
// Self-checking bench: a MEM_LATENCY=1 arbiter for functional tests and a
// MEM_LATENCY=3 arbiter for saturation, each with its own behavioural bank.
module tb_memory_bank_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;

    logic       req0 = 1'b0, write0 = 1'b0, req1 = 1'b0, write1 = 1'b0;
    logic [1:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       ack0, ack1, busy, mem_write;
    logic [7:0] rdata, mem_data_in, mem_data_out;
    logic [1:0] mem_addr;

    logic       req0_b = 1'b0, write0_b = 1'b0, req1_b = 1'b0, write1_b = 1'b0;
    logic [1:0] addr0_b = '0, addr1_b = '0;
    logic [7:0] wdata0_b = '0, wdata1_b = '0;
    logic       ack0_b, ack1_b, busy_b, mem_write_b;
    logic [7:0] rdata_b, mem_data_in_b, mem_data_out_b;
    logic [1:0] mem_addr_b;

    logic [7:0] bank_a [4] = '{default: 8'h00};
    logic [7:0] bank_b [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    logic [7:0] model_a [4] = '{default: 8'h00};

    typedef struct {
        logic       port;
        logic [7:0] data;
    } exp_t;
    exp_t sb [$];

    int total = 0;
    int bad   = 0;

    // Behavioural banks: combinational read, write-through during a write cycle.
    assign mem_data_out = mem_write ? mem_data_in : bank_a[mem_addr];
    always @(posedge clk) if (mem_write) bank_a[mem_addr] <= mem_data_in;
    assign mem_data_out_b = mem_write_b ? mem_data_in_b : bank_b[mem_addr_b];
    always @(posedge clk) if (mem_write_b) bank_b[mem_addr_b] <= mem_data_in_b;

    memory_bank_arbiter #(.LINE_LENGTH(8), .ADDRESS_SIZE(2), .MEM_LATENCY(1)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .write0(write0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .write1(write1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .busy(busy), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_write(mem_write), .mem_data_out(mem_data_out)
    );

    memory_bank_arbiter #(.LINE_LENGTH(8), .ADDRESS_SIZE(2), .MEM_LATENCY(3)) u_dut_b (
        .clk(clk), .reset(reset),
        .req0(req0_b), .write0(write0_b), .addr0(addr0_b), .wdata0(wdata0_b), .ack0(ack0_b),
        .req1(req1_b), .write1(write1_b), .addr1(addr1_b), .wdata1(wdata1_b), .ack1(ack1_b),
        .rdata(rdata_b), .busy(busy_b), .mem_addr(mem_addr_b), .mem_data_in(mem_data_in_b),
        .mem_write(mem_write_b), .mem_data_out(mem_data_out_b)
    );

    task automatic drive_port(input logic p, input logic r, input logic w,
                              input logic [1:0] a, input logic [7:0] d);
        if (p) begin
            req1 = r; write1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; write0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; req0_b = 1'b0; req1_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++; if ({ack0, ack1, busy, mem_write} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0000", {ack0, ack1, busy, mem_write});
        end
        total++; if (rdata !== 8'h00) begin
            bad++; $display("FAIL reset_rdata: got %h want 00", rdata);
        end
        total++; if ({mem_addr, mem_data_in} !== 10'h000) begin
            bad++; $display("FAIL reset_mem_bus: got %h want 000", {mem_addr, mem_data_in});
        end
        total++; if ({ack0_b, ack1_b, busy_b, mem_write_b} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl_b: got %b want 0000", {ack0_b, ack1_b, busy_b, mem_write_b});
        end
        reset = 1'b0;
    endtask

    // One transaction on the latency-1 arbiter; optionally drops req mid-ACCESS.
    task automatic test_txn(input logic p, input logic w, input logic [1:0] a,
                            input logic [7:0] d, input bit drop);
        exp_t e;
        int   pulses = 0;
        int   wcyc   = -1;
        int   acyc   = -1;
        if (w) model_a[a] = d;
        e.port = p; e.data = model_a[a];
        sb.push_back(e);
        drive_port(p, 1'b1, w, a, d);
        for (int k = 1; k <= 20 && acyc < 0; k++) begin
            @(negedge clk);
            if (drop && k == 1) drive_port(p, 1'b0, w, a, d);
            if (mem_write) begin
                pulses++; wcyc = k;
            end
            if (ack0 || ack1) begin
                acyc = k;
                total++; if (sb.size() == 0) begin
                    bad++; $display("FAIL txn_unexpected_ack: got ack with empty queue want none");
                end else begin
                    e = sb.pop_front();
                    if ({ack0, ack1} !== (e.port ? 2'b01 : 2'b10)) begin
                        bad++; $display("FAIL txn_ack_port: got %b want port %0d", {ack0, ack1}, e.port);
                    end
                    total++; if (rdata !== e.data) begin
                        bad++; $display("FAIL txn_rdata: got %h want %h", rdata, e.data);
                    end
                end
                drive_port(p, 1'b0, w, a, d);
            end
        end
        total++; if (acyc != 2) begin
            bad++; $display("FAIL txn_ack_cycle: got %0d want 2", acyc);
        end
        total++; if (pulses != int'(w) || (w && wcyc != 1)) begin
            bad++; $display("FAIL txn_write_pulse: got %0d pulses at %0d want %0d at 1", pulses, wcyc, w);
        end
        @(negedge clk);
        @(negedge clk);
        total++; if ({busy, ack0, ack1} !== 3'b000) begin
            bad++; $display("FAIL txn_idle_after: got %b want 000", {busy, ack0, ack1});
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        int   acks  = 0;
        int   first = -1;
        int   second = -1;
        apply_reset();
        e.port = 1'b0; e.data = model_a[2]; sb.push_back(e);
        model_a[3] = 8'h5A;
        e.port = 1'b1; e.data = 8'h5A; sb.push_back(e);
        drive_port(1'b0, 1'b1, 1'b0, 2'd2, 8'h00);
        drive_port(1'b1, 1'b1, 1'b1, 2'd3, 8'h5A);
        for (int k = 1; k <= 20 && acks < 2; k++) begin
            @(negedge clk);
            if (ack0 && ack1) begin
                total++; bad++; $display("FAIL sim_overlap: got both acks want one");
            end
            if (ack0 || ack1) begin
                e = sb.pop_front();
                total++; if ({ack0, ack1} !== (e.port ? 2'b01 : 2'b10)) begin
                    bad++; $display("FAIL sim_order: got %b want port %0d", {ack0, ack1}, e.port);
                end
                total++; if (rdata !== e.data) begin
                    bad++; $display("FAIL sim_rdata: got %h want %h", rdata, e.data);
                end
                if (acks == 0) first = k; else second = k;
                acks++;
                drive_port(ack1, 1'b0, 1'b0, 2'd0, 8'h00);
            end
        end
        total++; if (first != 2 || second != 5) begin
            bad++; $display("FAIL sim_timing: got acks at %0d,%0d want 2,5", first, second);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        apply_reset();
        drive_port(1'b1, 1'b1, 1'b1, 2'd1, 8'h3C);
        @(negedge clk);
        total++; if ({busy, mem_write} !== 2'b11) begin
            bad++; $display("FAIL abort_access: got %b want 11", {busy, mem_write});
        end
        reset = 1'b1;
        drive_port(1'b1, 1'b0, 1'b1, 2'd1, 8'h3C);
        #1;
        total++; if (mem_write !== 1'b0) begin
            bad++; $display("FAIL abort_write_gate: got %b want 0", mem_write);
        end
        @(negedge clk);
        total++; if ({ack1, busy, mem_write} !== 3'b000) begin
            bad++; $display("FAIL abort_ctrl: got %b want 000", {ack1, busy, mem_write});
        end
        total++; if ({rdata, mem_addr, mem_data_in} !== 18'h0) begin
            bad++; $display("FAIL abort_data_cleared: got %h want 0", {rdata, mem_addr, mem_data_in});
        end
        @(negedge clk);
        total++; if (ack1 !== 1'b0) begin
            bad++; $display("FAIL abort_no_ack: got %b want 0", ack1);
        end
        reset = 1'b0;
        test_txn(1'b0, 1'b0, 2'd1, 8'h00, 1'b0);
    endtask

    task automatic test_saturation();
        exp_t e;
        int   acks = 0;
        int   last = -1;
        bit   wseen = 0;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            e.port = 1'b0;
`else
            e.port = i[0];
`endif
            e.data = e.port ? 8'h10 : 8'h13;
            sb.push_back(e);
        end
        req0_b = 1'b1; addr0_b = 2'd3;
        req1_b = 1'b1; addr1_b = 2'd0;
        for (int k = 1; k <= 80 && acks < 8; k++) begin
            @(negedge clk);
            if (mem_write_b) wseen = 1;
            if (ack0_b || ack1_b) begin
                e = sb.pop_front();
                total++; if ({ack0_b, ack1_b} !== (e.port ? 2'b01 : 2'b10)) begin
                    bad++; $display("FAIL sat_grant%0d: got %b want port %0d", acks, {ack0_b, ack1_b}, e.port);
                end
                total++; if (rdata_b !== e.data) begin
                    bad++; $display("FAIL sat_rdata%0d: got %h want %h", acks, rdata_b, e.data);
                end
                total++; if ((acks == 0 && k != 4) || (acks != 0 && k - last != 5)) begin
                    bad++; $display("FAIL sat_spacing%0d: got cycle %0d prev %0d want 4 then +5", acks, k, last);
                end
                last = k;
                acks++;
            end
        end
        req0_b = 1'b0; req1_b = 1'b0;
        total++; if (acks != 8) begin
            bad++; $display("FAIL sat_count: got %0d acks want 8", acks);
        end
        total++; if (wseen) begin
            bad++; $display("FAIL sat_no_write: got a write pulse want none");
        end
        sb.delete();
        repeat (6) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_txn(1'b0, 1'b1, 2'd2, 8'hA5, 1'b0);
        test_txn(1'b0, 1'b0, 2'd2, 8'h00, 1'b0);
        test_txn(1'b1, 1'b0, 2'd2, 8'h00, 1'b0);
        test_txn(1'b1, 1'b1, 2'd0, 8'h96, 1'b0);
        test_txn(1'b0, 1'b0, 2'd2, 8'h00, 1'b1);
        test_simultaneous();
        test_reset_abort();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_bank_arbiter.md
Name: memory_bank_arbiter

Overview:
Shares one single-port memory_bank between two requesters (port 0: fetch side, port 1: data side) with round-robin arbitration. Each request is a single-word read or write. The block holds the bank for MEM_LATENCY cycles, then returns read data and a one-cycle ack. It sits between the pipeline's memory-access stages and the bank instance.

Parameters:
LINE_LENGTH, 8, word width in bits; must match the bank.
ADDRESS_SIZE, 2, address width; bank depth is 1<<ADDRESS_SIZE.
MEM_LATENCY, 1, cycles the bank is held per access; legal range 1..15.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
req0  input  1  request from port 0; held high until ack0.
write0  input  1  port 0: 1 = write, 0 = read.
addr0  input  ADDRESS_SIZE  port 0 address.
wdata0  input  LINE_LENGTH  port 0 write data.
ack0  output  1  one-cycle completion pulse to port 0.
req1, write1, addr1, wdata1, ack1  as for port 0, for port 1.
rdata  output  LINE_LENGTH  read data; valid only in the ack cycle.
busy  output  1  high whenever state != IDLE.
mem_addr  output  ADDRESS_SIZE  to bank addr.
mem_data_in  output  LINE_LENGTH  to bank data_in.
mem_write  output  1  to bank write.
mem_data_out  input  LINE_LENGTH  from bank data_out (combinational read).

Behaviour:
- Reset (sampled at the edge): state=IDLE, prio pointer=0, count=0, and all latches cleared. ack0, ack1, busy and mem_write read 0; rdata, mem_addr and mem_data_in read 0.
- mem_write is gated with ~reset, so no write pulse can occur in a cycle where reset is high.
- FSM IDLE:
  - Requests are sampled only in IDLE.
  - If any req is high, pick the winner: the only requester, or on a tie the requester named by the prio pointer.
  - Latch winner id, write, addr and wdata.
  - Set count=MEM_LATENCY-1 and go to ACCESS.
- FSM ACCESS:
  - mem_addr and mem_data_in are driven from the latches.
  - mem_write = latched write AND count==0 (exactly one cycle per write).
  - While count!=0, decrement count.
  - When count==0, capture mem_data_out into rdata and go to RESP.
- FSM RESP:
  - ack of the winner = 1 for this cycle only.
  - rdata holds the captured word. For writes it holds the bank's post-write read of the address.
  - Prio pointer is set to the non-winner. Go to IDLE.
- Latency: req sampled at cycle 0 → write pulse / read capture at cycle MEM_LATENCY → ack at cycle MEM_LATENCY+1.
  - Minimum 3 cycles per transaction including the IDLE sample cycle.
- A requester deasserts req in the cycle after its ack. If req is still high in IDLE, it is a new request.
- Dropping req during ACCESS or RESP does not cancel the transaction; it completes and acks.
- Request inputs are ignored outside IDLE; a losing requester simply waits.
- Reset mid-ACCESS or mid-RESP aborts: no ack and no write pulse is issued.
- With both ports continuously requesting, grants alternate 0,1,0,1… Neither port waits more than one transaction.
- Address width equals the bank's; no wrap or bounds logic.

Optional Feature:
MEM_ARB_FIXED_PRIO_EN:
- Defined: ties always go to port 0, the prio pointer is not updated, and port 1 may starve.
- Undefined: round-robin as above.
- Both builds share the same ports and timing.

Decomposition:
- Package mem_arb_pkg: state encoding (IDLE, ACCESS, RESP), port ids PORT0=0 and PORT1=1, and the count width constant (4 bits).
- Sub-module rr_pick2: combinational 2-way picker; inputs req0, req1, prio; outputs winner and valid. It absorbs the MEM_ARB_FIXED_PRIO_EN selection.

Test Plan:
- Write then read (MEM_LATENCY=1): port 0 writes 8'hA5 to addr 2; port 0 reads addr 2 → mem_write high exactly 1 cycle at cycle 1; ack0 at cycle 2; read ack with rdata=8'hA5.
- Simultaneous: req0 and req1 rise together after reset → ack0 first, then ack1 3 cycles later; ack1 never overlaps ack0.
- Saturation, 8 transactions, MEM_LATENCY=3, both ports held: grants alternate 0,1,0,1…; ack every 5 cycles.
- Reset at the first ACCESS cycle of a port 1 write of 8'h3C to addr 1 → no ack1, no mem_write; addr 1 reads 8'h00 afterwards.
- req0 dropped mid-ACCESS → ack0 still pulses; next IDLE grants nothing.
- MEM_ARB_FIXED_PRIO_EN defined, both held 6 transactions → all six acks go to port 0, none to port 1.
